// File: rtl/xconnect_port_arb.sv
`default_nettype none
// ============================================================================
//  Module   : xconnect_port_arb
//  Brief    : Per-destination output arbiter of the xconnect fabric. Picks one
//             source lane round-robin, locks onto it until the packet's last
//             word, and forwards words through one registered valid/ready
//             output stage.
//  Revision : 1.0  initial release
// ============================================================================
module xconnect_port_arb #(
  parameter int WORD_SIZE = 256,
  parameter int NOF_PES   = 16,
  localparam int SRC_W    = $clog2(NOF_PES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NOF_PES-1:0]           i_src_valid,
  input  logic [NOF_PES*WORD_SIZE-1:0] i_src_data,
  input  logic [NOF_PES-1:0]           i_src_last,
  output logic [NOF_PES-1:0]           o_src_ready,
  output logic                         o_out_valid,
  output logic [WORD_SIZE-1:0]         o_out_data,
  output logic                         o_out_last,
  output logic [SRC_W-1:0]             o_out_src,
  input  logic                         i_out_ready
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SRC_W-1:0]     r_rr_ptr;
  logic [SRC_W-1:0]     w_rr_nxt;
  logic [SRC_W-1:0]     r_lock_id;
  logic [SRC_W-1:0]     w_lock_nxt;

  logic                 r_out_valid;
  logic [WORD_SIZE-1:0] r_out_data;
  logic                 r_out_last;
  logic [SRC_W-1:0]     r_out_src;

  logic                 w_can_acc;
  logic                 w_rr_found;
  logic [SRC_W-1:0]     w_rr_grant;
  logic [SRC_W-1:0]     w_sel;
  logic                 w_sel_valid;
  logic                 w_sel_last;
  logic                 w_xfer;
  logic [WORD_SIZE-1:0] w_lane_data [NOF_PES];

  // The output register can take a new word when empty or draining this cycle.
  assign w_can_acc = !r_out_valid || i_out_ready;

  // Round-robin search: first valid lane starting at r_rr_ptr, wrapping modulo NOF_PES.
  always_comb begin
    logic [SRC_W-1:0] w_idx;
    w_rr_found = 1'b0;
    w_rr_grant = r_rr_ptr;
    w_idx      = r_rr_ptr;
    // Descending scan so the smallest offset from the pointer wins.
    for (int k = NOF_PES - 1; k >= 0; k--) begin
      w_idx = r_rr_ptr + SRC_W'(k);
      if (i_src_valid[w_idx]) begin
        w_rr_found = 1'b1;
        w_rr_grant = w_idx;
      end
    end
  end

  // While locked the lane is fixed; other lanes are ignored even if valid.
  assign w_sel       = (r_state == S_IDLE) ? w_rr_grant : r_lock_id;
  assign w_sel_valid = (r_state == S_IDLE) ? w_rr_found : i_src_valid[r_lock_id];
  assign w_sel_last  = i_src_last[w_sel];
  assign w_xfer      = !rst && w_sel_valid && w_can_acc;

  // Per-lane data unpacking and one-hot ready generation.
  generate
    for (genvar i = 0; i < NOF_PES; i++) begin : g_lane
      assign w_lane_data[i] = i_src_data[i*WORD_SIZE +: WORD_SIZE];
      assign o_src_ready[i] = w_xfer && (w_sel == SRC_W'(i));
    end
  endgenerate

  // Next-state logic for arbitration state, round-robin pointer and lock id.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_lock_nxt  = r_lock_id;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          if (w_sel_last) begin
            // Single-beat packet: the granted source drops to lowest priority.
            w_rr_nxt = w_rr_grant + SRC_W'(1);
          end else begin
            w_state_nxt = S_LOCKED;
            w_lock_nxt  = w_rr_grant;
          end
        end
      end
      S_LOCKED: begin
        if (w_xfer && w_sel_last) begin
          w_state_nxt = S_IDLE;
          w_rr_nxt    = r_lock_id + SRC_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_lock_id <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_lock_id <= w_lock_nxt;
    end
  end

  // Output stage: load on transfer, drain on ready, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_src   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_lane_data[w_sel];
      r_out_last  <= w_sel_last;
      r_out_src   <= w_sel;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_last  = r_out_last;
  assign o_out_src   = r_out_src;

endmodule
`default_nettype wire
